// File: rtl/rv32_program_loader.sv
`timescale 1ns/1ps
// Byte-stream loader for the single-cycle RV32 core: fills instruction memory
// through the core's Write/WE_mem/WD_mem port, then restarts the core at PC 0.

module rv32_program_loader #(
  parameter int ADDR_W     = 10,
  parameter int MAX_WORDS  = 256,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_rst,
  output logic        Write,
  output logic        WE_mem,
  output logic [31:0] WD_mem,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  words_loaded
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_HDR0    = 3'd2;
  localparam logic [2:0] ST_HDR1    = 3'd3;
  localparam logic [2:0] ST_BYTES   = 3'd4;
  localparam logic [2:0] ST_WAIT_PC = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [15:0]       nwords_q, nwords_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wd_q, wd_d;
  logic [8:0]        words_q, words_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [RC_W-1:0]   rel_cnt_q, rel_cnt_d;

  logic              accept_s;
  logic              match_s;
  logic [15:0]       hdr_n_s;
  logic              hdr_bad_s;
  logic              last_word_s;

  assign accept_s    = in_valid & in_ready;
  assign match_s     = (pc_q == word_addr_q);
  assign hdr_n_s     = {in_data, nwords_q[7:0]};
  assign hdr_bad_s   = (hdr_n_s == 16'd0) || (hdr_n_s > 16'(MAX_WORDS));
  assign last_word_s = (({7'd0, words_q} + 16'd1) == nwords_q);

  // Handshake and core-control outputs decoded from the state flops.
  always_comb begin
    in_ready = 1'b0;
    Write    = 1'b0;
    core_rst = 1'b1;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        core_rst = ~done_q;
        busy     = 1'b0;
      end
      ST_SYNC: begin
        Write = 1'b1;
      end
      ST_HDR0, ST_HDR1, ST_BYTES: begin
        in_ready = 1'b1;
        Write    = 1'b1;
        core_rst = 1'b0;
      end
      ST_WAIT_PC: begin
        Write    = 1'b1;
        core_rst = 1'b0;
      end
      ST_RELEASE: begin
        Write = 1'b0;
      end
      ST_ERR: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // The commit strobe fires only while the core's PC (mirrored) sits on the word's address.
  assign WE_mem       = (state_q == ST_WAIT_PC) && match_s;
  assign WD_mem       = wd_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

  // Next-state logic for the load sequence and the PC mirror.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    word_addr_d = word_addr_q;
    nwords_d    = nwords_q;
    byte_cnt_d  = byte_cnt_q;
    wd_d        = wd_q;
    words_d     = words_q;
    done_d      = done_q;
    err_d       = err_q;
    rel_cnt_d   = rel_cnt_q;

    // Core PC is held at 0 during SYNC and free-runs by 4 while Write is high afterwards.
    if ((state_q == ST_HDR0) || (state_q == ST_HDR1) ||
        (state_q == ST_BYTES) || (state_q == ST_WAIT_PC)) begin
      pc_d = pc_q + ADDR_W'(4);
    end else if (state_q == ST_SYNC) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (load_start) begin
          state_d = ST_SYNC;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = 9'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SYNC: begin
        words_d = 9'd0;
        state_d = ST_HDR0;
      end
      ST_HDR0: begin
        if (accept_s) begin
          nwords_d[7:0] = in_data;
          state_d       = ST_HDR1;
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (accept_s) begin
          nwords_d[15:8] = in_data;
          if (hdr_bad_s) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            word_addr_d = '0;
            byte_cnt_d  = 2'd0;
            state_d     = ST_BYTES;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_BYTES: begin
        if (accept_s) begin
          wd_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_WAIT_PC;
          end else begin
            state_d = ST_BYTES;
          end
        end else begin
          state_d = ST_BYTES;
        end
      end
      ST_WAIT_PC: begin
        if (match_s) begin
          words_d     = words_q + 9'd1;
          word_addr_d = word_addr_q + ADDR_W'(4);
          if (last_word_s) begin
            rel_cnt_d = '0;
            state_d   = ST_RELEASE;
          end else begin
            state_d = ST_BYTES;
          end
        end else begin
          state_d = ST_WAIT_PC;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + RC_W'(1);
          state_d   = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      word_addr_q <= '0;
      nwords_q    <= 16'd0;
      byte_cnt_q  <= 2'd0;
      wd_q        <= 32'd0;
      words_q     <= 9'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rel_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      word_addr_q <= word_addr_d;
      nwords_q    <= nwords_d;
      byte_cnt_q  <= byte_cnt_d;
      wd_q        <= wd_d;
      words_q     <= words_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rel_cnt_q   <= rel_cnt_d;
    end
  end

endmodule

// File: doc/rv32_program_loader.md
# rv32_program_loader

Byte-stream program loader that fills the single-cycle RV32 core's instruction memory through its `WE_mem`/`WD_mem`/`Write` load port, then restarts the core at PC 0. While `Write` is high, the core fetches a forced-zero instruction and advances PC by 4 every clock, wrapping at 1024 bytes. The loader keeps a mirror of that PC and commits each assembled word in the cycle the core's PC equals the word's byte address. It sits between a byte source (UART RX or testbench) and the core top.

## Interface
- `ADDR_W`, 10: core PC / instruction-memory byte-address width.
- `MAX_WORDS`, 256: largest accepted word count, equal to 2^ADDR_W/4.
- `RST_CYCLES`, 2: number of cycles `core_rst` is held after the load completes (≥1).

- `clk`  in  1  clock.
- `Reset`  in  1  asynchronous, active-high reset. Clock is `clk`.
- `load_start`  in  1  single-cycle start request; ignored while `busy`.
- `in_valid`  in  1  byte-source valid.
- `in_data`  in  8  byte-source data.
- `in_ready`  out  1  loader accepts a byte on a cycle where `in_valid & in_ready`.
- `core_rst`  out  1  drives the core's `Reset`.
- `Write`  out  1  drives the core's `Write` (fetch blank, PC free-runs).
- `WE_mem`  out  1  instruction-memory write enable.
- `WD_mem`  out  32  instruction-memory write data.
- `busy`  out  1  high from SYNC through RELEASE.
- `done`  out  1  level; set on a successful load, cleared by the next accepted `load_start`.
- `err`  out  1  level; set on a bad header, cleared by the next accepted `load_start`.
- `words_loaded`  out  9  number of words committed in the current or last load.

## Operation
- States: IDLE, SYNC, HDR0, HDR1, BYTES, WAIT_PC, RELEASE, ERR.
- IDLE: `core_rst` = 1 after `Reset`. After a successful load it is 0, so the core runs. `load_start` moves to SYNC.
- SYNC (1 cycle): `core_rst` = 1, `Write` = 1, `pc_mirror` ← 0, `words_loaded` ← 0, `done`/`err` ← 0. Then go to HDR0.
- HDR0, HDR1: accept the word count N, 16-bit little-endian (low byte first). After HDR1:
  - N = 0 or N > `MAX_WORDS` → ERR.
  - Otherwise `word_addr` ← 0 and go to BYTES.
- BYTES: accept 4 bytes, little-endian, into the 32-bit word register (first byte is [7:0]). After the 4th byte, go to WAIT_PC.
- WAIT_PC: `in_ready` = 0. `WE_mem` = (`pc_mirror` == `word_addr`), decoded combinationally from flops. On the match cycle:
  - `words_loaded`++ and `word_addr` += 4.
  - If `words_loaded` + 1 == N → RELEASE, else → BYTES.
- RELEASE: `Write` = 0, `core_rst` = 1 for `RST_CYCLES` cycles. Then `done` ← 1 and go to IDLE with `core_rst` = 0.
- ERR: `Write` = 0, `core_rst` = 1, `err` = 1. Stay until `load_start`, which goes to SYNC.
- `pc_mirror`:
  - Increments by 4 modulo 2^ADDR_W on every clock while in HDR0, HDR1, BYTES or WAIT_PC.
  - Matches the core's PC cycle-for-cycle, because the core PC is held at 0 by `core_rst` in SYNC.
- `in_ready` = 1 only in HDR0, HDR1 and BYTES. Bytes offered at any other time are not consumed.
- `load_start` in any state other than IDLE or ERR is ignored.
- `Write` = 1 in SYNC through WAIT_PC, 0 elsewhere. `WD_mem` holds the word register at all times.

## Timing
- Reset values:
  - state IDLE, `core_rst` 1, `Write` 0, `WE_mem` 0, `WD_mem` 0.
  - `in_ready` 0, `busy` 0, `done` 0, `err` 0.
  - `words_loaded` 0, `pc_mirror` 0.
- `Reset` mid-load aborts immediately to reset values. A partial image stays in memory and the core is held in reset.
- Each handshake consumes one byte per cycle at most. With continuous `in_valid`, a word is assembled in 4 cycles.
- Commit latency:
  - The memory write happens on the clock edge ending the match cycle.
  - The match cycle comes 1–256 cycles after the 4th byte is accepted, depending on mirror phase.
  - If `pc_mirror` == `word_addr` in the first WAIT_PC cycle, the commit happens in that cycle.
- `WE_mem` is high exactly one cycle per word. Words are committed in address order 0, 4, …, 4(N−1).
- The core fetches address 0 on the first cycle after RELEASE ends, with `Write` = 0 and `core_rst` = 0.

## Test plan
- Reset: assert `Reset` mid-BYTES → all outputs at reset values, `core_rst` = 1, `in_ready` = 0.
- One word: `load_start`, then bytes 01 00 13 05 A0 00 →
  - exactly one `WE_mem` pulse, with `WD_mem` = 0x00A00513 while `pc_mirror` = 0.
  - then `core_rst` high for 2 cycles, `done` = 1, `words_loaded` = 1.
- Three words, bytes back-to-back → commits at mirror 0x000, 0x004, 0x008, in order, one pulse each, with the correct data.
- Bad header:
  - 00 00 → `err` = 1, `Write` = 0, `core_rst` = 1, no `WE_mem`.
  - 01 01 (257) → same response.
  - A following `load_start` clears `err`.
- Backpressure: `in_valid` toggling randomly, plus bytes held during WAIT_PC → no byte is lost or duplicated, and the word data is exact.
- `load_start` pulsed during BYTES is ignored. A 256-word load commits address 0x3FC last and wraps `pc_mirror` correctly.
